// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and the register-match helper for the hazard controller
package hazard_ctrl_pkg;

    typedef logic [4:0] regidx_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        F_RUN   = 1'b0,
        F_DRAIN = 1'b1
    } fetch_state_t;

    // A stage supplies register r only if it writes a non-zero destination equal to r
    function automatic logic regMatch(input logic regWrite, input regidx_t writeReg, input regidx_t r);
        return regWrite & (writeReg != 5'd0) & (writeReg == r);
    endfunction

endpackage

// File: rtl/hazard_ctrl_forward.sv
// forward_unit: operand forwarding selects and producer/consumer match terms
module forward_unit
    import hazard_ctrl_pkg::*;
(
    input  regidx_t  RsD,
    input  regidx_t  RtD,
    input  regidx_t  RsE,
    input  regidx_t  RtE,
    input  regidx_t  WriteRegE,
    input  regidx_t  WriteRegM,
    input  regidx_t  WriteRegW,
    input  logic     RegWriteE,
    input  logic     RegWriteM,
    input  logic     RegWriteW,
    input  logic     MemtoRegM,
    output fwd_sel_t fwdAE,
    output fwd_sel_t fwdBE,
    output logic     fwdAD,
    output logic     fwdBD,
    output logic     matchEsD,
    output logic     matchEtD,
    output logic     matchMsD,
    output logic     matchMtD
);

    // M is the younger producer, so it wins over W; a load in M has no data yet for D
    always_comb begin
        matchEsD = regMatch(RegWriteE, WriteRegE, RsD);
        matchEtD = regMatch(RegWriteE, WriteRegE, RtD);
        matchMsD = regMatch(RegWriteM, WriteRegM, RsD);
        matchMtD = regMatch(RegWriteM, WriteRegM, RtD);
        fwdAE = regMatch(RegWriteM, WriteRegM, RsE) ? FWD_M :
                regMatch(RegWriteW, WriteRegW, RsE) ? FWD_W : FWD_RF;
        fwdBE = regMatch(RegWriteM, WriteRegM, RtE) ? FWD_M :
                regMatch(RegWriteW, WriteRegW, RtE) ? FWD_W : FWD_RF;
        fwdAD = matchMsD & ~MemtoRegM;
        fwdBD = matchMtD & ~MemtoRegM;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control, fetch-discard sequencing and stall counter
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ireq_valid,
    input  logic             iresp_data_ok,
    input  logic             dreq_valid,
    input  logic             dresp_data_ok,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             MduE,
    input  logic             mdu_busy,
    input  logic             ExcM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             redirect,
    output logic             ifetch_discard,
    output logic [CNT_W-1:0] stall_cnt
);

    fetch_state_t     state;
    logic [CNT_W-1:0] stallCnt;
    fwd_sel_t         fwdAE, fwdBE;
    logic             fwdAD, fwdBD;
    logic             matchEsD, matchEtD, matchMsD, matchMtD;
    logic             luHaz, brHaz, mdHaz, dWait, iWait;
    logic             memHold, excTake, lower, holdD, holdE;

    forward_unit uFwd (
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegE (WriteRegE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteE (RegWriteE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .MemtoRegM (MemtoRegM),
        .fwdAE     (fwdAE),
        .fwdBE     (fwdBE),
        .fwdAD     (fwdAD),
        .fwdBD     (fwdBD),
        .matchEsD  (matchEsD),
        .matchEtD  (matchEtD),
        .matchMsD  (matchMsD),
        .matchMtD  (matchMtD)
    );

    // A dbus wait freezes F..M and masks ExcM; below that, lower-priority holds OR together and
    // a stage is only bubbled when the stage behind it is not being held
    always_comb begin
        luHaz   = MemtoRegE & (matchEsD | matchEtD);
        brHaz   = BranchD & (matchEsD | matchEtD | (MemtoRegM & (matchMsD | matchMtD)));
        mdHaz   = MduE & mdu_busy;
        dWait   = dreq_valid & ~dresp_data_ok;
        iWait   = (ireq_valid & ~iresp_data_ok) | (state == F_DRAIN);
        memHold = resetn & dWait;
        excTake = resetn & ~dWait & ExcM;
        lower   = resetn & ~dWait & ~ExcM;
        holdE   = lower & mdHaz;
        holdD   = lower & (mdHaz | luHaz | brHaz);
        StallF  = memHold | holdD | (lower & iWait);
        StallD  = memHold | holdD;
        StallE  = memHold | holdE;
        StallM  = memHold;
        StallW  = 1'b0;
        FlushD  = excTake | (lower & iWait & ~holdD);
        FlushE  = excTake | (lower & (luHaz | brHaz) & ~holdE);
        FlushM  = excTake | holdE;
        FlushW  = memHold;
        redirect       = excTake;
        ifetch_discard = resetn & ((state == F_DRAIN) | (excTake & iresp_data_ok));
        ForwardAE = resetn ? fwdAE : FWD_RF;
        ForwardBE = resetn ? fwdBE : FWD_RF;
        ForwardAD = resetn & fwdAD;
        ForwardBD = resetn & fwdBD;
    end

    // Drain a fetch left outstanding by a redirect; count every cycle the fetch stage is held
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= F_RUN;
            stallCnt <= '0;
        end else begin
            stallCnt <= stallCnt + CNT_W'(StallF);
            state    <= (state == F_DRAIN) ? (iresp_data_ok ? F_RUN : F_DRAIN) :
                        ((redirect & ireq_valid & ~iresp_data_ok) ? F_DRAIN : F_RUN);
        end
    end

    assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checking of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic          sf, sd, se, sm, sw;
        logic          fd, fe, fm, fw;
        logic [1:0]    fae, fbe;
        logic          fad, fbd, redir, disc;
        logic [CW-1:0] cnt;
    } outs_t;

    logic clk = 1'b0;
    logic resetn;
    logic ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MduE, mdu_busy, ExcM;
    logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic ForwardAD, ForwardBD, redirect, ifetch_discard;
    logic [CW-1:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit checkEn = 0;
    bit mDrain = 0;
    int mCnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn),
        .ireq_valid(ireq_valid), .iresp_data_ok(iresp_data_ok),
        .dreq_valid(dreq_valid), .dresp_data_ok(dresp_data_ok),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MduE(MduE), .mdu_busy(mdu_busy), .ExcM(ExcM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .redirect(redirect), .ifetch_discard(ifetch_discard), .stall_cnt(stall_cnt)
    );

    function automatic bit mt(input logic we, input logic [4:0] wr, input logic [4:0] r);
        return we && wr != 5'd0 && wr == r;
    endfunction

    // Outputs the rules demand for the present inputs, given whether a discard drain is pending
    function automatic outs_t model(input bit drain, input int cnt);
        outs_t e;
        bit lu, br, md, dw, iw;
        e = '0;
        e.cnt = CW'(cnt);
        if (!resetn) return e;
        e.fae = mt(RegWriteM, WriteRegM, RsE) ? 2'd2 : mt(RegWriteW, WriteRegW, RsE) ? 2'd1 : 2'd0;
        e.fbe = mt(RegWriteM, WriteRegM, RtE) ? 2'd2 : mt(RegWriteW, WriteRegW, RtE) ? 2'd1 : 2'd0;
        e.fad = mt(RegWriteM, WriteRegM, RsD) && !MemtoRegM;
        e.fbd = mt(RegWriteM, WriteRegM, RtD) && !MemtoRegM;
        lu = MemtoRegE && (mt(RegWriteE, WriteRegE, RsD) || mt(RegWriteE, WriteRegE, RtD));
        br = BranchD && (mt(RegWriteE, WriteRegE, RsD) || mt(RegWriteE, WriteRegE, RtD) ||
             (MemtoRegM && (mt(RegWriteM, WriteRegM, RsD) || mt(RegWriteM, WriteRegM, RtD))));
        md = MduE && mdu_busy;
        dw = dreq_valid && !dresp_data_ok;
        iw = (ireq_valid && !iresp_data_ok) || drain;
        if (dw) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
        end else if (ExcM) begin
            e.fd = 1; e.fe = 1; e.fm = 1; e.redir = 1;
        end else begin
            if (md) begin e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1; end
            if (lu || br) begin e.sf = 1; e.sd = 1; e.fe = !e.se; end
            if (iw) begin e.sf = 1; e.fd = !e.sd; end
        end
        e.disc = drain || (e.redir && iresp_data_ok);
        return e;
    endfunction

    function automatic outs_t actual();
        return {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW,
                ForwardAE, ForwardBE, ForwardAD, ForwardBD, redirect, ifetch_discard, stall_cnt};
    endfunction

    // Model state advances on the same edges as the DUT
    always @(posedge clk) begin
        outs_t e;
        e = model(mDrain, mCnt);
        if (!resetn) begin
            mDrain = 0;
            mCnt = 0;
        end else begin
            mCnt = (mCnt + int'(e.sf)) % (1 << CW);
            mDrain = mDrain ? !iresp_data_ok : (e.redir && ireq_valid && !iresp_data_ok);
        end
    end

    // Mid-cycle comparison of every output against the model
    always @(negedge clk) begin
        outs_t e, a;
        if (checkEn) begin
            e = model(mDrain, mCnt);
            a = actual();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL model t=%0t got=%h want=%h", $time, a, e);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        {ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok} = '0;
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MduE, mdu_busy, ExcM} = '0;
    endtask

    task automatic randomize_inputs();
        {ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok} = 4'($urandom);
        RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
        RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
        WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
        WriteRegW = 5'($urandom_range(0, 3));
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MduE, mdu_busy} = 8'($urandom);
        ExcM = ($urandom_range(0, 3) == 0);
    endtask

    task automatic setLoadUse();
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5'd2; RsD = 5'd2;
    endtask

    initial begin
        resetn = 0;
        randomize_inputs();
        tick();
        checkEn = 1;
        tick();
        settle();
        lit("reset_stall", {StallF, StallD, FlushD, FlushE, redirect, ifetch_discard}, 0);
        lit("reset_cnt", stall_cnt, 0);

        resetn = 1; idle(); setLoadUse(); settle();
        lit("lu_hold", {StallF, StallD, FlushE, StallE, FlushD}, 5'b11100);
        tick(); idle(); settle();
        lit("lu_clear", {StallF, StallD, FlushE}, 0);
        lit("lu_cnt", stall_cnt, 1);

        RegWriteM = 1; WriteRegM = 5'd5; RegWriteW = 1; WriteRegW = 5'd5; RsE = 5'd5; settle();
        lit("fwd_m_prio", ForwardAE, 2'b10);
        WriteRegM = 5'd0; settle();
        lit("fwd_w", ForwardAE, 2'b01);
        RsE = 5'd0; WriteRegW = 5'd0; settle();
        lit("fwd_zero", ForwardAE, 2'b00);
        tick(); idle();

        dreq_valid = 1; ExcM = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            lit("dwait_hold", {StallF, StallD, StallE, StallM, FlushW, redirect, FlushD}, 7'b1111100);
            tick();
        end
        dresp_data_ok = 1; settle();
        lit("dwait_exc", {redirect, FlushD, FlushE, FlushM, StallF, StallD}, 6'b111100);
        tick(); idle();

        ExcM = 1; ireq_valid = 1; settle();
        lit("drain_enter", {redirect, ifetch_discard}, 2'b10);
        tick(); idle();
        for (int i = 0; i < 2; i++) begin
            settle();
            lit("drain_hold", {ifetch_discard, StallF, FlushD}, 3'b111);
            tick();
        end
        iresp_data_ok = 1; settle();
        lit("drain_resp", {ifetch_discard, StallF}, 2'b11);
        tick(); idle(); settle();
        lit("drain_done", {ifetch_discard, StallF}, 2'b00);

        MduE = 1; mdu_busy = 1; setLoadUse(); settle();
        lit("md_lu", {StallF, StallD, StallE, FlushM, FlushE}, 5'b11110);
        tick(); idle();

        setLoadUse();
        for (int i = 0; i < 20 && stall_cnt != 4'hF; i++) tick();
        settle();
        lit("wrap_reach", stall_cnt, 4'hF);
        tick(); settle();
        lit("wrap_zero", stall_cnt, 0);
        idle();

        ExcM = 1; ireq_valid = 1; tick(); idle(); settle();
        lit("rst_drain_pre", ifetch_discard, 1);
        resetn = 0; tick(); settle();
        lit("rst_drain_gated", {ifetch_discard, StallF}, 0);
        resetn = 1; settle();
        lit("rst_drain_post", {ifetch_discard, StallF, stall_cnt}, 0);
        tick();

        for (int i = 0; i < 2000; i++) begin
            randomize_inputs();
            resetn = ($urandom_range(0, 63) != 0);
            tick();
        end
        @(negedge clk);
        checkEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage MIPS pipeline (F/D/E/M/W stage registers, each with Stall*/Flush* inputs).
- Resolves load-use and branch-operand hazards and generates forwarding selects.
- Freezes the pipe on ibus/dbus waits and on multiply/divide busy.
- On exceptions, flushes the pipe and sequences discard of an in-flight instruction fetch via a small FSM.
- Keeps a stall-cycle performance counter.

Parameters:
CNT_W, 32, width of stall-cycle counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock; single clock domain
resetn  in  1  reset, synchronous, active-low
ireq_valid  in  1  fetch request outstanding this cycle
iresp_data_ok  in  1  fetch response returned this cycle
dreq_valid  in  1  M-stage data request outstanding
dresp_data_ok  in  1  data response returned this cycle
RsD, RtD, RsE, RtE  in  5 each  source register indices (regidx_t)
WriteRegE, WriteRegM, WriteRegW  in  5 each  destination indices
RegWriteE, RegWriteM, RegWriteW  in  1 each  writeback enables
MemtoRegE, MemtoRegM  in  1 each  stage holds a load
BranchD  in  1  D holds a branch/jump-register that compares operands in D
MduE  in  1  E holds a mult/div/mfhi/mflo
mdu_busy  in  1  multiply/divide unit busy
ExcM  in  1  exception/ERET committed in M
StallF, StallD, StallE, StallM, StallW  out  1 each  stage-register hold
FlushD, FlushE, FlushM, FlushW  out  1 each  stage-register bubble
ForwardAE, ForwardBE  out  2 each  00 regfile, 01 from W, 10 from M
ForwardAD, ForwardBD  out  1 each  D-stage compare forward from M
redirect  out  1  PC loads exception vector this cycle
ifetch_discard  out  1  drop the current/next iresp
stall_cnt  out  CNT_W  cycles with StallF=1

Behaviour:
- Reset (resetn=0 at posedge): fetch FSM -> F_RUN, stall_cnt -> 0. While resetn=0, all Stall*/Flush*/redirect/ifetch_discard = 0 and Forward* = 0.
- Sequential state: fetch FSM and stall_cnt only. All other outputs are combinational from inputs and state (0-cycle latency).
- Define match(x,r) = RegWrite_x & (WriteReg_x != 0) & (WriteReg_x == r).
- Forwarding:
  - ForwardAE = 10 if match(M,RsE); else 01 if match(W,RsE); else 00. M has priority over W. B-side same with RtE.
  - ForwardAD = match(M,RsD) & ~MemtoRegM. ForwardBD same with RtD.
- Hazard terms:
  - lu = MemtoRegE & (match(E,RsD) | match(E,RtD)).
  - br = BranchD & (match(E,RsD) | match(E,RtD) | (MemtoRegM & (match(M,RsD) | match(M,RtD)))).
  - md = MduE & mdu_busy.
  - d_wait = dreq_valid & ~dresp_data_ok.
  - i_wait = (ireq_valid & ~iresp_data_ok) | (state == F_DRAIN).
- Priority (highest first):
  1. d_wait: StallF, StallD, StallE, StallM = 1; FlushW = 1; all others 0. ExcM is ignored this cycle; M is held, so ExcM re-presents later.
  2. ExcM: FlushD, FlushE, FlushM = 1; redirect = 1; StallF = 0; all other stalls 0.
  3. md: StallF, StallD, StallE = 1; FlushM = 1.
  4. lu | br: StallF, StallD = 1; FlushE = 1.
  5. i_wait: StallF = 1; FlushD = 1, but only if StallD = 0.
  - Terms at levels 3–5 combine by OR (e.g. lu with i_wait: StallF=StallD=1, FlushE=1, FlushD=0).
  - StallW is always 0; W is bubbled with FlushW, never held.
- Fetch FSM (fetch_state_t: F_RUN, F_DRAIN):
  - F_RUN:
    - redirect & ireq_valid & ~iresp_data_ok -> F_DRAIN.
    - redirect & iresp_data_ok -> stay F_RUN, ifetch_discard = 1 this cycle.
  - F_DRAIN:
    - ifetch_discard = 1; StallF = 1 (through i_wait).
    - iresp_data_ok -> F_RUN; the response arriving that cycle is discarded.
    - A further ExcM while in F_DRAIN: stay F_DRAIN, redirect = 1 again.
  - Fetch unit must not launch a new ireq while ifetch_discard = 1.
- stall_cnt: +1 at each posedge where StallF = 1 and resetn = 1; wraps from all-ones to 0.
- Reset mid-drain: FSM returns to F_RUN; the stale response is the fetch unit's responsibility (it is reset too).

Decomposition:
- Add to mycpu/type.svh:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - fetch_state_t enum.
- Sub-module forward_unit: purely combinational; produces Forward*E/*D and match terms; instantiated once.
- FSM, priority logic and counter live in hazard_ctrl.

Test Plan:
- lw $2 in E (MemtoRegE=1, RegWriteE=1, WriteRegE=2), RsD=2 -> StallF=StallD=1, FlushE=1, next cycle (MemtoRegE=0) all clear; stall_cnt increments by 1.
- RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RsE=5 -> ForwardAE=10; WriteRegM=0 with RsE=0 -> ForwardAE=00.
- dreq_valid=1, dresp_data_ok=0 for 3 cycles with ExcM=1 -> StallF..StallM=1, FlushW=1, redirect=0 each cycle; on data_ok -> redirect=1, FlushD/E/M=1.
- ExcM=1 with ireq_valid=1, iresp_data_ok=0 -> redirect=1, state F_DRAIN, ifetch_discard=1 and StallF=1 for 2 cycles; iresp_data_ok=1 -> discard that cycle, F_RUN next.
- MduE=1, mdu_busy=1 together with lu=1 -> StallF=StallD=StallE=1, FlushM=1, FlushE=0.
- Preload stall_cnt near wrap (force 32'hFFFF_FFFF via held StallF) -> next stall cycle reads 0; resetn=0 in F_DRAIN -> F_RUN, stall_cnt=0.
